// File: rtl/pattern_scan_ctrl.sv
// Round-robin front end for a shared bit-serial pattern detector: grants one requester,
// clears the detector, shifts the latched frame MSB-first and returns a saturating match count.
module pattern_scan_ctrl #(
  parameter int NREQ    = 4,
  parameter int FRAME_W = 16,
  parameter int CNT_W   = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*FRAME_W-1:0]   frame_data,
  output logic [NREQ-1:0]           gnt,
  output logic                      done,
  output logic [$clog2(NREQ)-1:0]   done_id,
  output logic [CNT_W-1:0]          match_cnt,
  output logic                      det_clr,
  output logic                      det_datain,
  input  logic                      det_dataout
);

  localparam int ID_W  = $clog2(NREQ);
  localparam int BIT_W = $clog2(FRAME_W);

  typedef enum logic [2:0] {IDLE, CLR, SHIFT, DRAIN, DONE} state_t;

  state_t             state, state_nxt;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    gnt_id;
  logic [ID_W-1:0]    pick_id;
  logic [FRAME_W-1:0] shift_reg;
  logic [BIT_W-1:0]   bit_idx;
  logic [CNT_W-1:0]   cnt;
  logic               sample;

  // First requesting index at or after rr_ptr, wrapping at NREQ-1.
  always_comb begin
    logic found;
    found   = 1'b0;
    pick_id = '0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        found   = 1'b1;
        pick_id = ID_W'(idx);
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    det_clr    = 1'b0;
    det_datain = 1'b0;
    case (state)
      IDLE:  if (|req) state_nxt = CLR;
      CLR: begin
        det_clr   = 1'b1;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        det_datain = shift_reg[bit_idx];
        if (bit_idx == '0) state_nxt = DRAIN;
      end
      DRAIN: state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The detector output lags the driven bit by one cycle, so the first SHIFT
  // cycle carries nothing from this frame and DRAIN carries the last bit.
  assign sample = ((state == SHIFT) && (bit_idx != BIT_W'(FRAME_W - 1))) || (state == DRAIN);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      done      <= 1'b0;
      done_id   <= '0;
      match_cnt <= '0;
      rr_ptr    <= '0;
      gnt_id    <= '0;
      shift_reg <= '0;
      bit_idx   <= '0;
      cnt       <= '0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      case (state)
        IDLE: if (|req) begin
          gnt       <= NREQ'(1) << pick_id;
          gnt_id    <= pick_id;
          shift_reg <= frame_data[pick_id*FRAME_W +: FRAME_W];
          cnt       <= '0;
        end
        CLR:   bit_idx <= BIT_W'(FRAME_W - 1);
        SHIFT: if (bit_idx != '0) bit_idx <= bit_idx - 1'b1;
        DRAIN: gnt <= '0;
        DONE: begin
          done      <= 1'b1;
          done_id   <= gnt_id;
          match_cnt <= cnt;
          rr_ptr    <= (int'(gnt_id) == NREQ - 1) ? '0 : gnt_id + 1'b1;
        end
        default: ;
      endcase
      if (sample && det_dataout && (cnt != '1)) cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Directed bench for pattern_scan_ctrl with a registered 1101011 detector model
// and a second CNT_W=3 instance whose detector input is tied high.
module tb_pattern_scan_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [3:0]  req;
  logic [63:0] frame_data;
  logic [3:0]  gnt;
  logic        done;
  logic [1:0]  done_id;
  logic [7:0]  match_cnt;
  logic        det_clr, det_datain;
  logic        det_dataout = 1'b0;

  logic [3:0]  req_s = 4'b0000;
  logic [3:0]  gnt_s;
  logic        done_s;
  logic [1:0]  done_id_s;
  logic [2:0]  match_cnt_s;
  logic        det_clr_s, det_datain_s;

  int total = 0;
  int bad   = 0;

  pattern_scan_ctrl #(.NREQ(4), .FRAME_W(16), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .frame_data(frame_data),
    .gnt(gnt), .done(done), .done_id(done_id), .match_cnt(match_cnt),
    .det_clr(det_clr), .det_datain(det_datain), .det_dataout(det_dataout)
  );

  pattern_scan_ctrl #(.NREQ(4), .FRAME_W(16), .CNT_W(3)) u_sat (
    .clk(clk), .rst_n(rst_n), .req(req_s), .frame_data(frame_data),
    .gnt(gnt_s), .done(done_s), .done_id(done_id_s), .match_cnt(match_cnt_s),
    .det_clr(det_clr_s), .det_datain(det_datain_s), .det_dataout(1'b1)
  );

  // Detector model: overlapping 1101011 matcher with a registered flag.
  logic [5:0] hist = '0;
  always @(posedge clk) begin
    if (det_clr) begin
      hist        <= '0;
      det_dataout <= 1'b0;
    end else begin
      hist        <= {hist[4:0], det_datain};
      det_dataout <= ({hist, det_datain} == 7'b1101011);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One service from the sampling edge (edge 0) to the done strobe (edge 19).
  task automatic serve(input string tag, input logic [3:0] r, input logic [3:0] g,
                       input logic [1:0] id, input logic [7:0] cnt,
                       input logic [15:0] bits, input bit mutate);
    int          n;
    int          clrs;
    logic [15:0] seen;
    bit          got_done;
    req = r;
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".gnt"}, 64'(gnt), 64'(g));
    n        = 0;
    clrs     = int'(det_clr);
    seen     = '0;
    got_done = 1'b0;
    while (!got_done && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (det_clr) clrs++;
      if (n >= 1 && n <= 16) seen[16 - n] = det_datain;
      if (mutate && n == 6) frame_data = ~frame_data;
      if (n == 17) chk({tag, ".gnt_held"}, 64'(gnt), 64'(g));
      if (done) got_done = 1'b1;
    end
    chk({tag, ".done_at"}, 64'(n), 64'd19);
    chk({tag, ".clr_pulses"}, 64'(clrs), 64'd1);
    chk({tag, ".datain_seq"}, 64'(seen), 64'(bits));
    chk({tag, ".done_id"}, 64'(done_id), 64'(id));
    chk({tag, ".match_cnt"}, 64'(match_cnt), 64'(cnt));
    chk({tag, ".gnt_off"}, 64'(gnt), 64'd0);
  endtask

  initial begin
    int n;
    int dones;
    rst_n      = 1'b0;
    req        = 4'b1111;
    frame_data = {16'h006B, 16'hD6B0, 16'h0000, 16'hD600};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.gnt", 64'(gnt), 64'd0);
    chk("rst.done", 64'(done), 64'd0);
    chk("rst.done_id", 64'(done_id), 64'd0);
    chk("rst.match_cnt", 64'(match_cnt), 64'd0);
    chk("rst.det_clr", 64'(det_clr), 64'd0);
    chk("rst.det_datain", 64'(det_datain), 64'd0);
    rst_n = 1'b1;

    // All requesters held high: order 0,1,2,3,0 with back-to-back services.
    serve("rr0", 4'b1111, 4'b0001, 2'd0, 8'd1, 16'hD600, 1'b0);
    serve("rr1", 4'b1111, 4'b0010, 2'd1, 8'd0, 16'h0000, 1'b0);
    serve("rr2", 4'b1111, 4'b0100, 2'd2, 8'd2, 16'hD6B0, 1'b0);
    serve("rr3", 4'b1111, 4'b1000, 2'd3, 8'd1, 16'h006B, 1'b0);
    serve("rr4", 4'b1111, 4'b0001, 2'd0, 8'd1, 16'hD600, 1'b0);
    req = 4'b0000;

    frame_data = {16'h0000, 16'hD600, 16'h0000, 16'h0000};
    serve("single", 4'b0100, 4'b0100, 2'd2, 8'd1, 16'hD600, 1'b0);
    req = 4'b0000;

    frame_data = {16'hD6B0, 48'h0};
    serve("freeze", 4'b1000, 4'b1000, 2'd3, 8'd2, 16'hD6B0, 1'b1);
    req = 4'b0000;

    // Abort during the 8th SHIFT cycle.
    frame_data = {16'h0000, 16'h0000, 16'hFFFF, 16'h0000};
    req = 4'b0010;
    @(posedge clk);
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    req   = 4'b0000;
    @(posedge clk);
    @(negedge clk);
    chk("abort.gnt", 64'(gnt), 64'd0);
    chk("abort.det_clr", 64'(det_clr), 64'd0);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("abort.no_done", 64'(dones), 64'd0);
    frame_data = {16'h0000, 16'h0000, 16'h006B, 16'h0000};
    serve("fresh", 4'b0010, 4'b0010, 2'd1, 8'd1, 16'h006B, 1'b0);
    req = 4'b0000;

    // Saturation: 16 sampled match cycles into a 3-bit counter.
    req_s = 4'b0001;
    @(posedge clk);
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (done_s) break;
    end
    req_s = 4'b0000;
    chk("sat.done_at", 64'(n), 64'd19);
    chk("sat.match_cnt", 64'(match_cnt_s), 64'd7);
    chk("sat.done_id", 64'(done_id_s), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pattern_scan_ctrl.md
Name: pattern_scan_ctrl

Overview:
- Arbitrates NREQ requesters that share one bit-serial pattern detector; the detector flags a 7-bit sequence such as 1101011 and has a registered one-cycle output.
- Round-robin grant; the granted frame is latched, the detector is cleared, and the frame is shifted MSB-first.
- Detector match pulses are counted over the frame, and the count is returned with a done strobe.
- Sits between the requester bank and the shared detector instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- FRAME_W, 16, bits per frame shifted into the detector.
- CNT_W, 8, width of the match counter; the counter saturates.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- req  in  NREQ  per-requester service request, level.
- frame_data  in  NREQ*FRAME_W  frames; requester i occupies bits [i*FRAME_W +: FRAME_W].
- gnt  out  NREQ  one-hot grant, held for the whole service.
- done  out  1  one-cycle strobe; the service has finished.
- done_id  out  clog2(NREQ)  index of the requester just served; valid while done=1.
- match_cnt  out  CNT_W  match count for the served frame; valid while done=1, held until the next done.
- det_clr  out  1  synchronous clear to the detector; the detector is in IDLE the cycle after.
- det_datain  out  1  serial bit to the detector.
- det_dataout  in  1  detector match flag; reflects the bit driven in the previous cycle.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low, on rst_n.
- Reset values: state=IDLE; gnt=0, done=0, done_id=0, match_cnt=0, det_clr=0, det_datain=0; rr pointer=0, so requester 0 has highest priority first.
- Reset mid-service: the service is aborted. No done is issued and gnt drops on the next edge.
- FSM states: IDLE, CLR, SHIFT, DRAIN, DONE.
- IDLE:
  - If any req bit is high, select the first requester at or after rr_ptr, scanning upward with wrap at NREQ-1.
  - Register gnt one-hot, latch that requester's frame into shift_reg, and clear the internal counter.
  - Go to CLR. With no req, stay in IDLE with det_datain=0.
- CLR:
  - det_clr=1 and det_datain=0 for exactly one cycle.
  - bit_idx=FRAME_W-1. Go to SHIFT.
- SHIFT:
  - det_datain=shift_reg[bit_idx].
  - From the second SHIFT cycle on, if det_dataout=1 the counter increments.
  - When bit_idx=0, go to DRAIN; otherwise decrement bit_idx.
- DRAIN:
  - det_datain=0. Sample det_dataout once more to catch a match on the final bit.
  - Go to DONE.
- DONE:
  - done=1, done_id=granted index, match_cnt=counter; gnt=0.
  - rr_ptr=(granted index+1) mod NREQ. Go to IDLE.
- Timing: done is asserted FRAME_W+3 cycles after the IDLE edge that sampled req. The next grant can occur the cycle after DONE, so back-to-back services are possible.
- Counter saturation: the counter saturates at 2^CNT_W-1 and never wraps.
- Match counting:
  - det_dataout is ignored in IDLE, CLR, DONE and the first SHIFT cycle.
  - Overlapping matches count separately, exactly as the detector reports them.
- req handling:
  - req is sampled only in IDLE; req changes during service are ignored.
  - Frame data is frozen at grant, so frame_data changes mid-service have no effect.
  - A requester holding req high after its done is re-served only after rr order passes it.
- Simultaneous requests: pure round-robin with no starvation. With all req high, the grant order is 0,1,2,..,NREQ-1,0,...
- Requester index: done_id is the registered index, not the one-hot gnt.

Test Plan:
- Reset: hold rst_n=0 with req=4'b1111 for 3 cycles -> all outputs 0 and no gnt. After release, gnt=4'b0001 on the first IDLE edge.
- Single match:
  - Use a bench detector model for 1101011; req[2]=1 with frame 16'hD600.
  - Required: gnt=4'b0100, det_clr pulses once, det_datain sequence 1101011000000000.
  - Required: done at cycle 19 after the req sample, done_id=2, match_cnt=1.
- Zero and overlap:
  - Frame 16'h0000 -> match_cnt=0.
  - Frame 16'b1101011010110000 -> match_cnt equals the model's overlap count (2 for an overlapping-capable model). This checks sampling of the final bit via DRAIN.
- Round-robin: req=4'b1111 held for 5 services -> done_id sequence 0,1,2,3,0, with no idle gap beyond DONE->IDLE.
- Saturation: CNT_W=3, detector stub drives det_dataout=1 constantly -> match_cnt=7, not 0 or 15.
- Abort and freeze:
  - rst_n=0 during the 8th SHIFT cycle -> no done, gnt=0 next edge. The next service completes normally with a fresh count.
  - Changing frame_data mid-SHIFT does not alter det_datain.
